// File: rtl/alu_optr_pkg.sv
// ALU operation codes produced by the instruction decoder.
package ALUOptr;
  typedef enum logic [3:0] {
    ADD, SUB, SLT, SLTU, ANDL, ORL, XORL, NORL,
    SLLV, SRLV, SRAV, LUI, TIMES, TIMESU, DIV, DIVU
  } ALUOptr_t;
endpackage

// File: rtl/mdu_hilo_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package MduPkg;
  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = MDU_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} MduState_t;

  function automatic logic isMduOp(ALUOptr::ALUOptr_t op);
    return op inside {ALUOptr::TIMES, ALUOptr::TIMESU, ALUOptr::DIV, ALUOptr::DIVU};
  endfunction

  function automatic logic isSignedOp(ALUOptr::ALUOptr_t op);
    return (op == ALUOptr::TIMES) || (op == ALUOptr::DIV);
  endfunction
endpackage

// File: rtl/mdu_hilo_if.sv
// Execute-stage <-> MDU bus: operation launch, MTHI/MTLO, and HI/LO/status back.
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic              start;
  ALUOptr::ALUOptr_t optr;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              kill;
  logic              mthi;
  logic              mtlo;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;
  logic              busy;
  logic              done;

  modport master (output start, optr, a, b, kill, mthi, mtlo, wdata,
                  input  hi, lo, busy, done);
  modport slave  (input  start, optr, a, b, kill, mthi, mtlo, wdata,
                  output hi, lo, busy, done);
endinterface

// File: rtl/mdu_hilo_step.sv
// One iteration of the magnitude datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide, selected by isDiv.
module mdu_step #(parameter int WIDTH = 32) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               curBit,
  output logic [2*WIDTH-1:0] accNext,
  output logic               qBit
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] remSub;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (curBit ? {1'b0, mcand} : '0);
    remShift = {acc[2*WIDTH-1:WIDTH], curBit};
    qBit     = remShift >= {1'b0, divisor};
    // True difference is below 2^WIDTH whenever it is taken, so modulo math is exact.
    remSub   = remShift[WIDTH-1:0] - divisor;
    if (isDiv)
      accNext = {(qBit ? remSub : remShift[WIDTH-1:0]), acc[WIDTH-1:0]};
    else
      accNext = {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MDU with architectural HI/LO: operands are reduced to magnitudes,
// iterated WIDTH times, then sign-fixed in a final FIX cycle.
module mdu_hilo
  import MduPkg::*;
#(parameter int WIDTH = MDU_WIDTH) (
  input logic        clk,
  input logic        rst_n,
  mdu_hilo_if.slave  bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  MduState_t          state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   opA, opB, hiQ, loQ;
  logic [2*WIDTH-1:0] acc, stepAcc, prod;
  logic [WIDTH-1:0]   aMag, bMag, quo, rem;
  logic               negQ, negR, opDiv, busyQ, doneQ;
  logic               sgn, launch, stepBit, qBit;

  assign sgn    = isSignedOp(bus.optr);
  assign launch = bus.start && isMduOp(bus.optr) && !bus.kill;
  assign aMag   = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign bMag   = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply consumes the multiplier LSB-first; divide consumes the dividend MSB-first.
  assign stepBit = (state == DIV) ? opA[LAST - count] : opB[count];

  mdu_step #(.WIDTH(WIDTH)) uStep (
    .isDiv   (state == DIV),
    .acc     (acc),
    .mcand   (opA),
    .divisor (opB),
    .curBit  (stepBit),
    .accNext (stepAcc),
    .qBit    (qBit)
  );

  assign prod = negQ ? -acc : acc;
  assign quo  = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      opA   <= '0;
      opB   <= '0;
      acc   <= '0;
      hiQ   <= '0;
      loQ   <= '0;
      negQ  <= 1'b0;
      negR  <= 1'b0;
      opDiv <= 1'b0;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (state != IDLE && bus.kill) begin
        state <= IDLE;
        busyQ <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (launch) begin
              opDiv <= (bus.optr == ALUOptr::DIV) || (bus.optr == ALUOptr::DIVU);
              opA   <= aMag;
              opB   <= bMag;
              negQ  <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              negR  <= sgn && bus.a[WIDTH-1];
              acc   <= '0;
              count <= '0;
              busyQ <= 1'b1;
              state <= ((bus.optr == ALUOptr::DIV) || (bus.optr == ALUOptr::DIVU)) ? DIV : MUL;
            end else begin
              if (bus.mthi) hiQ <= bus.wdata;
              if (bus.mtlo) loQ <= bus.wdata;
            end
          end
          MUL, DIV: begin
            if (state == DIV)
              acc <= {stepAcc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], qBit};
            else
              acc <= stepAcc;
            count <= count + 1'b1;
            if (count == LAST) state <= FIX;
          end
          FIX: begin
            if (opDiv) begin
              hiQ <= rem;
              loQ <= quo;
            end else begin
              hiQ <= prod[2*WIDTH-1:WIDTH];
              loQ <= prod[WIDTH-1:0];
            end
            doneQ <= 1'b1;
            busyQ <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.hi   = hiQ;
  assign bus.lo   = loQ;
  assign bus.busy = busyQ;
  assign bus.done = doneQ;
endmodule
